// File: rtl/stream_upsizer_pkg.sv
// ============================================================================
//  Module      : stream_upsizer_pkg
//  Description : Shared width helpers for the stream up/down sizer family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_upsizer_pkg;

    // Ceiling log2 for elaboration-time width derivation (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width for a lane count: never narrower than one bit.
    function automatic int cnt_width(input int ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_upsizer_rise_detect.sv
// ============================================================================
//  Module      : rise_detect
//  Description : Per-bit rising-edge detector, one cycle of history.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_rise
);

    logic [DATA_WIDTH-1:0] r_q;

    // Remember the previous sample of the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

`default_nettype wire

// File: rtl/stream_upsizer.sv
// ============================================================================
//  Module      : stream_upsizer
//  Description : Packs RATIO narrow beats into one wide registered word, with
//                early flush on last_in, per-lane keep, selectable lane order
//                and a kernel-start clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IN_WIDTH-1:0]       din,
    input  logic                      vld_in,
    input  logic                      last_in,
    output logic                      rdy_upward,
    output logic [IN_WIDTH*RATIO-1:0] dout,
    output logic [RATIO-1:0]          keep_out,
    output logic                      last_out,
    output logic                      vld_out,
    input  logic                      rdy_downward,
    input  logic                      ap_start
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_W     = cnt_width(RATIO);
    localparam int OFF_W     = cnt_width(OUT_WIDTH);

    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_gbuf;
    logic [RATIO-1:0]     r_gkeep;
    logic [OUT_WIDTH-1:0] r_dout;
    logic [RATIO-1:0]     r_keep_out;
    logic                 r_last_out;
    logic                 r_vld_out;

    logic                 w_rst;
    logic [0:0]           w_rise_vec;
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_complete;
    logic [CNT_W-1:0]     w_lane;
    logic [OFF_W-1:0]     w_off;
    logic [OUT_WIDTH-1:0] w_merged;
    logic [RATIO-1:0]     w_keep_merged;

    assign w_rst = !reset_n;

    rise_detect #(
        .DATA_WIDTH(1)
    ) u_rise_detect (
        .clk    (clk),
        .rst    (w_rst),
        .i_d    (ap_start),
        .o_rise (w_rise_vec)
    );

    assign w_rise = w_rise_vec[0];

    // The kernel-start clear wins over everything, so no beat may be taken then.
    assign rdy_upward = reset_n && !w_rise && (!r_vld_out || rdy_downward);
    assign w_accept   = vld_in && rdy_upward;
    assign w_complete = w_accept && ((r_cnt == CNT_W'(RATIO - 1)) || last_in);

    // Keep bits follow fill order; only the data lane position is mirrored.
    assign w_lane        = (LSB_FIRST != 0) ? r_cnt : (CNT_W'(RATIO - 1) - r_cnt);
    assign w_off         = OFF_W'(w_lane) * OFF_W'(IN_WIDTH);
    assign w_keep_merged = r_gkeep | (RATIO'(1) << r_cnt);

    // Gather buffer with the current beat dropped into its lane.
    always_comb begin
        w_merged                      = r_gbuf;
        w_merged[w_off +: IN_WIDTH]   = din;
    end

    // Gather state: fill lanes, restart on completion or kernel start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_gbuf  <= '0;
            r_gkeep <= '0;
        end else if (w_rise || w_complete) begin
            r_cnt   <= '0;
            r_gbuf  <= '0;
            r_gkeep <= '0;
        end else if (w_accept) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_gbuf  <= w_merged;
            r_gkeep <= w_keep_merged;
        end
    end

    // Output register: load on completion, drop valid once drained, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= '0;
            r_keep_out <= '0;
            r_last_out <= 1'b0;
            r_vld_out  <= 1'b0;
        end else if (w_rise) begin
            r_dout     <= '0;
            r_keep_out <= '0;
            r_last_out <= 1'b0;
            r_vld_out  <= 1'b0;
        end else if (w_complete) begin
            r_dout     <= w_merged;
            r_keep_out <= w_keep_merged;
            r_last_out <= last_in;
            r_vld_out  <= 1'b1;
        end else if (r_vld_out && rdy_downward) begin
            r_vld_out  <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign keep_out = r_keep_out;
    assign last_out = r_last_out;
    assign vld_out  = r_vld_out;

endmodule

`default_nettype wire

// File: tb/tb_stream_upsizer.sv
// ============================================================================
//  Module      : tb_stream_upsizer
//  Description : Self-checking bench, RATIO=4 in both lane orders.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_upsizer;

    logic         clk;
    logic         reset_n;
    logic [31:0]  din;
    logic         vld_in;
    logic         last_in;
    logic         rdy_downward;
    logic         ap_start;

    logic         rdy_a, rdy_b;
    logic [127:0] dout_a, dout_b;
    logic [3:0]   keep_a, keep_b;
    logic         last_a, last_b;
    logic         vld_a, vld_b;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int words  = 0;

    logic [127:0] m_a, m_b;
    logic [3:0]   m_keep;
    int           m_cnt;

    stream_upsizer #(.IN_WIDTH(32), .RATIO(4), .LSB_FIRST(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .din(din), .vld_in(vld_in), .last_in(last_in),
        .rdy_upward(rdy_a), .dout(dout_a), .keep_out(keep_a), .last_out(last_a),
        .vld_out(vld_a), .rdy_downward(rdy_downward), .ap_start(ap_start)
    );

    stream_upsizer #(.IN_WIDTH(32), .RATIO(4), .LSB_FIRST(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .din(din), .vld_in(vld_in), .last_in(last_in),
        .rdy_upward(rdy_b), .dout(dout_b), .keep_out(keep_b), .last_out(last_b),
        .vld_out(vld_b), .rdy_downward(rdy_downward), .ap_start(ap_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drained words are compared against the scoreboard in order.
    always @(negedge clk) begin
        if (reset_n && vld_a && rdy_downward) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got dout=%h, none expected", dout_a);
            end else begin
                exp_t ea, eb;
                ea = qa.pop_front();
                eb = qb.pop_front();
                words++;
                if (dout_a !== ea.d || keep_a !== ea.k || last_a !== ea.l ||
                    dout_b !== eb.d || keep_b !== eb.k || last_b !== eb.l) begin
                    errors++;
                    $display("FAIL word: got a=%h/%b/%b b=%h/%b/%b, want a=%h/%b/%b b=%h/%b/%b",
                             dout_a, keep_a, last_a, dout_b, keep_b, last_b,
                             ea.d, ea.k, ea.l, eb.d, eb.k, eb.l);
                end
            end
        end
    end

    task automatic model_clear();
        m_a = '0; m_b = '0; m_keep = '0; m_cnt = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input bit l);
        exp_t ea, eb;
        m_a[m_cnt*32 +: 32]     = d;
        m_b[(3-m_cnt)*32 +: 32] = d;
        m_keep[m_cnt]           = 1'b1;
        if (m_cnt == 3 || l) begin
            ea.d = m_a; ea.k = m_keep; ea.l = l;
            eb.d = m_b; eb.k = m_keep; eb.l = l;
            qa.push_back(ea);
            qb.push_back(eb);
            model_clear();
        end else begin
            m_cnt++;
        end
    endtask

    // Offer one beat until taken; returns 1 cycle after acceptance.
    task automatic send(input logic [31:0] d, input bit l, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        vld_in = 1'b1; din = d; last_in = l;
        while (!done) begin
            @(negedge clk);
            if (rdy_a) begin
                model_accept(d, l);
                done = 1;
            end else if (waits > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: beat %h not accepted, want accepted", d);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        vld_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vld_in = 1'b0; din = '0; last_in = 1'b0;
        rdy_downward = 1'b1; ap_start = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if (vld_a !== 1'b0)   begin errors++; $display("FAIL rst_vld: got %b want 0", vld_a); end
        checks++; if (dout_a !== '0)    begin errors++; $display("FAIL rst_dout: got %h want 0", dout_a); end
        checks++; if (keep_a !== 4'b0)  begin errors++; $display("FAIL rst_keep: got %b want 0", keep_a); end
        checks++; if (last_a !== 1'b0)  begin errors++; $display("FAIL rst_last: got %b want 0", last_a); end
        checks++; if (rdy_a !== 1'b0)   begin errors++; $display("FAIL rst_rdy: got %b want 0", rdy_a); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (rdy_a !== 1'b1)   begin errors++; $display("FAIL rdy_after_rst: got %b want 1", rdy_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        int w, tot;
        tot = 0;
        for (int i = 1; i <= 4; i++) begin
            send(32'(i * 32'h11), 1'b0, w);
            tot += w;
        end
        checks++; if (tot != 0) begin errors++; $display("FAIL b2b_stall: got %0d stalls want 0", tot); end
        @(negedge clk);
        checks++;
        if (vld_a !== 1'b1 || dout_a !== 128'h00000044_00000033_00000022_00000011 || keep_a !== 4'b1111) begin
            errors++; $display("FAIL full_lsb: got %b %h %b want 1 00000044000000330000002200000011 1111", vld_a, dout_a, keep_a);
        end
        checks++;
        if (dout_b !== 128'h00000011_00000022_00000033_00000044) begin
            errors++; $display("FAIL full_msb: got %h want 00000011000000220000003300000044", dout_b);
        end
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL vld_one_cycle: got %b want 0", vld_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_last_flush();
        int w;
        send(32'hA, 1'b0, w);
        send(32'hB, 1'b1, w);
        @(negedge clk);
        checks++;
        if (dout_a !== 128'h0000000B_0000000A || keep_a !== 4'b0011 || last_a !== 1'b1) begin
            errors++; $display("FAIL last_flush: got %h %b %b want 0000000b0000000a 0011 1", dout_a, keep_a, last_a);
        end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(32'(32'h20 + i), 1'b0, w);
        @(negedge clk);
        checks++;
        if (dout_a !== 128'h00000024_00000023_00000022_00000021) begin
            errors++; $display("FAIL after_last_lane0: got %h want 00000024000000230000002200000021", dout_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int w, w0;
        rdy_downward = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(32'h50 + i), 1'b0, w);
        w0 = words;
        fork
            begin
                int ws;
                for (int i = 0; i < 8; i++) send(32'(32'h80 + i), 1'b0, ws);
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks++;
                    if (rdy_a !== 1'b0 || vld_a !== 1'b1 ||
                        dout_a !== 128'h00000054_00000053_00000052_00000051) begin
                        errors++; $display("FAIL hold: got rdy=%b vld=%b dout=%h want 0 1 00000054000000530000005200000051", rdy_a, vld_a, dout_a);
                    end
                end
                @(posedge clk); #1;
                rdy_downward = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        checks++; if (words - w0 != 3) begin errors++; $display("FAIL drain_count: got %0d words want 3", words - w0); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL drain_left: got %0d pending want 0", qa.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_ap_start();
        int w;
        rdy_downward = 1'b1;
        send(32'h61, 1'b0, w);
        send(32'h62, 1'b0, w);
        vld_in = 1'b1; din = 32'h63; ap_start = 1'b1;
        @(negedge clk);
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL ap_rdy: got %b want 0", rdy_a); end
        @(posedge clk); #1;
        vld_in = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL ap_no_word: got %b want 0", vld_a); end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(32'(32'h70 + i), 1'b0, w);
        ap_start = 1'b0;
        @(negedge clk);
        checks++;
        if (vld_a !== 1'b1 || dout_a !== 128'h00000074_00000073_00000072_00000071 || keep_a !== 4'b1111) begin
            errors++; $display("FAIL ap_clean_word: got %b %h %b want 1 00000074000000730000007200000071 1111", vld_a, dout_a, keep_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w;
        rdy_downward = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(32'h90 + i), 1'b0, w);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (vld_a !== 1'b0 || dout_a !== '0 || keep_a !== 4'b0) begin
            errors++; $display("FAIL async_rst: got %b %h %b want 0 0 0000", vld_a, dout_a, keep_a);
        end
        qa.delete(); qb.delete();
        model_clear();
        @(posedge clk); #1;
        reset_n = 1'b1; rdy_downward = 1'b1;
        @(negedge clk);
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy: got %b want 1", rdy_a); end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(32'(32'hA0 + i), 1'b0, w);
        repeat (2) @(negedge clk);
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL rst_mid_resume: got %0d pending want 0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_last_flush();
        test_backpressure();
        test_ap_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
